// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SPRITE_W_DEF   = 12;
    localparam int SPRITE_H_DEF   = 12;
    localparam int SCALE_LOG2_DEF = 2;
    localparam int POS_SHIFT_DEF  = 2;

    localparam int SPRITE_N = SPRITE_W_DEF * SPRITE_H_DEF;
    localparam int SUB_MAX  = (1 << SCALE_LOG2_DEF) - 1;

    typedef enum logic [1:0] {
        V_WAIT,
        V_DRAW,
        V_DONE
    } v_state_t;

    typedef enum logic {
        H_IDLE,
        H_DRAW
    } h_state_t;

endpackage

// File: rtl/sprite_renderer_if.sv
// Bundle of SPI-side and raster-side signals between the receiver/timing and the renderer.
// Latency: n/a (wiring only).
// Backpressure: none; all strobes are single-cycle pulses.
interface sprite_renderer_if;

    logic       spi_sprite_shift;
    logic       spi_mosi_sync;
    logic       shift_x;
    logic       shift_y;
    logic       mirror_x;
    logic       mirror_y;
    logic [9:0] counter_h;
    logic [9:0] counter_v;
    logic       frame_start;
    logic       sprite_data;
    logic       sprite_pixel;
    logic [7:0] sprite_x;
    logic [7:0] sprite_y;

    modport master (
        output spi_sprite_shift, spi_mosi_sync, shift_x, shift_y,
        output mirror_x, mirror_y, counter_h, counter_v, frame_start,
        input  sprite_data, sprite_pixel, sprite_x, sprite_y
    );

    modport slave (
        input  spi_sprite_shift, spi_mosi_sync, shift_x, shift_y,
        input  mirror_x, mirror_y, counter_h, counter_v, frame_start,
        output sprite_data, sprite_pixel, sprite_x, sprite_y
    );

endinterface

// File: rtl/sprite_bitmap.sv
// Sprite bitmap: N-bit serial-in/serial-out shift register with a combinational random read port.
// Latency: shift takes effect on the next edge; read port is combinational.
// Backpressure: none; a shift is accepted every cycle it is pulsed.
module sprite_bitmap
    import sprite_pkg::*;
#(
    parameter int           N    = SPRITE_N,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 shift_en,
    input  logic                 shift_dat,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic                 rd_dat,
    output logic                 ser_dat
);

    logic [N-1:0] bits;

    // New bits enter at the top so the first bit sent ends up at pixel (0,0) after N shifts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bits <= INIT;
        end else if (shift_en) begin
            bits <= {shift_dat, bits[N-1:1]};
        end
    end

    assign rd_dat  = bits[rd_idx];
    assign ser_dat = bits[0];

endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: double-buffered position, raster-walking FSMs, registered per-pixel hit.
// Latency: sprite_pixel is 1 cycle after the counter_h value it belongs to.
// Backpressure: none; follows the raster every cycle.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int                               SPRITE_W       = SPRITE_W_DEF,
    parameter int                               SPRITE_H       = SPRITE_H_DEF,
    parameter int                               SCALE_LOG2     = SCALE_LOG2_DEF,
    parameter int                               POS_SHIFT      = POS_SHIFT_DEF,
    parameter logic [SPRITE_W*SPRITE_H-1:0]     SPRITE_DEFAULT = '0,
    parameter logic [7:0]                       X_DEFAULT      = 8'd0,
    parameter logic [7:0]                       Y_DEFAULT      = 8'd0
) (
    input logic               clk,
    input logic               reset_n,
    sprite_renderer_if.slave  bus
);

    localparam int N  = SPRITE_W * SPRITE_H;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [SW-1:0] SMAX     = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    logic [7:0] shadow_x, shadow_y, act_x, act_y;
    logic [9:0] x0, y0;
    logic       line_evt;

    v_state_t   v_state, v_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [SW-1:0] rsub, rsub_nxt;

    h_state_t   h_state, h_nxt;
    logic [CW-1:0] col, col_cur, col_nxt;
    logic [SW-1:0] csub, csub_cur, csub_nxt;
    logic       h_start, h_active;

    logic [CW-1:0] c_idx;
    logic [RW-1:0] r_idx;
    logic [IW-1:0] bit_idx;
    logic          bm_bit;
    logic          pixel_q;

    // Shadow registers take serial MSB-first writes; frame_start commits the pre-shift shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x <= X_DEFAULT;
            shadow_y <= Y_DEFAULT;
            act_x    <= X_DEFAULT;
            act_y    <= Y_DEFAULT;
        end else begin
            if (bus.frame_start) begin
                act_x <= shadow_x;
                act_y <= shadow_y;
            end
            if (bus.shift_x) shadow_x <= {shadow_x[6:0], bus.spi_mosi_sync};
            if (bus.shift_y) shadow_y <= {shadow_y[6:0], bus.spi_mosi_sync};
        end
    end

    assign x0       = {2'b00, act_x} << POS_SHIFT;
    assign y0       = {2'b00, act_y} << POS_SHIFT;
    assign line_evt = (bus.counter_h == 10'd0);

    // Vertical next state; it is also the view of the line that begins this cycle, so x0==0 draws at once.
    always_comb begin
        v_nxt    = v_state;
        row_nxt  = row;
        rsub_nxt = rsub;
        if (bus.frame_start) begin
            v_nxt    = V_WAIT;
            row_nxt  = '0;
            rsub_nxt = '0;
        end else if (line_evt) begin
            case (v_state)
                V_WAIT: begin
                    if (bus.counter_v == y0) begin
                        v_nxt    = V_DRAW;
                        row_nxt  = '0;
                        rsub_nxt = '0;
                    end
                end
                V_DRAW: begin
                    if (rsub == SMAX) begin
                        rsub_nxt = '0;
                        if (row == ROW_LAST) v_nxt = V_DONE;
                        else                 row_nxt = row + 1'b1;
                    end else begin
                        rsub_nxt = rsub + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Horizontal walk: col/csub describe the pixel drawn in the current cycle; a line event clips any overrun.
    always_comb begin
        h_start  = (v_nxt == V_DRAW) && (bus.counter_h == x0);
        h_active = h_start || ((h_state == H_DRAW) && !line_evt);
        col_cur  = h_start ? '0 : col;
        csub_cur = h_start ? '0 : csub;
        h_nxt    = H_IDLE;
        col_nxt  = col_cur;
        csub_nxt = csub_cur;
        if (h_active) begin
            h_nxt = H_DRAW;
            if (csub_cur == SMAX) begin
                csub_nxt = '0;
                if (col_cur == COL_LAST) h_nxt = H_IDLE;
                else                     col_nxt = col_cur + 1'b1;
            end else begin
                csub_nxt = csub_cur + 1'b1;
            end
        end
    end

    // Both raster FSMs advance together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_state <= V_DONE;
            row     <= '0;
            rsub    <= '0;
            h_state <= H_IDLE;
            col     <= '0;
            csub    <= '0;
        end else begin
            v_state <= v_nxt;
            row     <= row_nxt;
            rsub    <= rsub_nxt;
            h_state <= h_nxt;
            col     <= col_nxt;
            csub    <= csub_nxt;
        end
    end

    // Mirrored bitmap index; the multiply is by a constant so it folds into adders.
    always_comb begin
        c_idx   = bus.mirror_x ? (COL_LAST - col_cur) : col_cur;
        r_idx   = bus.mirror_y ? (ROW_LAST - row_nxt) : row_nxt;
        bit_idx = IW'(r_idx) * IW'(SPRITE_W) + IW'(c_idx);
    end

    sprite_bitmap #(
        .N    (N),
        .INIT (SPRITE_DEFAULT)
    ) u_bitmap (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (bus.spi_sprite_shift),
        .shift_dat (bus.spi_mosi_sync),
        .rd_idx    (bit_idx),
        .rd_dat    (bm_bit),
        .ser_dat   (bus.sprite_data)
    );

    // Registered hit for the colour mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pixel_q <= 1'b0;
        else          pixel_q <= h_active && (v_nxt == V_DRAW) && bm_bit;
    end

    assign bus.sprite_pixel = pixel_q;
    assign bus.sprite_x     = act_x;
    assign bus.sprite_y     = act_y;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a geometric reference model and a pixel scoreboard.
// Latency: expects each pixel hit one cycle after its counter_h.
// Backpressure: n/a.
module tb_sprite_renderer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sprite_renderer_if bus ();

    sprite_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [143:0] bm_m;
    logic [7:0]   shx, shy, ax, ay;
    bit           armed;
    logic         sb_q[$];

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bm_m  = '0;
        shx   = 8'd0;
        shy   = 8'd0;
        ax    = 8'd0;
        ay    = 8'd0;
        armed = 1'b0;
        sb_q.delete();
    endtask

    function automatic logic exp_pix();
        int x0, y0, h, v, col, row;
        if (!armed || bus.frame_start) return 1'b0;
        x0 = int'(ax) * 4;
        y0 = int'(ay) * 4;
        h  = int'(bus.counter_h);
        v  = int'(bus.counter_v);
        if (h < x0 || h >= x0 + 48 || v < y0 || v >= y0 + 48) return 1'b0;
        col = (h - x0) / 4;
        row = (v - y0) / 4;
        if (bus.mirror_x) col = 11 - col;
        if (bus.mirror_y) row = 11 - row;
        return bm_m[row * 12 + col];
    endfunction

    // Model effect of the edge just taken, using the inputs held over it.
    task automatic model_update();
        if (bus.frame_start) begin
            ax    = shx;
            ay    = shy;
            armed = 1'b1;
        end
        if (bus.shift_x)          shx  = {shx[6:0], bus.spi_mosi_sync};
        if (bus.shift_y)          shy  = {shy[6:0], bus.spi_mosi_sync};
        if (bus.spi_sprite_shift) bm_m = {bus.spi_mosi_sync, bm_m[143:1]};
    endtask

    // One clock: push the expected hit for the current inputs, then pop and compare the registered output.
    task automatic step();
        logic  e;
        string tag;
        tag = $sformatf("pixel h=%0d v=%0d", bus.counter_h, bus.counter_v);
        sb_q.push_back(exp_pix());
        @(posedge clk);
        #1;
        model_update();
        e = sb_q.pop_front();
        check(tag, {15'd0, bus.sprite_pixel}, {15'd0, e});
    endtask

    task automatic shift_bm(logic b);
        bus.spi_mosi_sync    = b;
        bus.spi_sprite_shift = 1'b1;
        step();
        bus.spi_sprite_shift = 1'b0;
    endtask

    task automatic shift_pos(bit is_y, logic [7:0] val);
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi_sync = val[i];
            if (is_y) bus.shift_y = 1'b1;
            else      bus.shift_x = 1'b1;
            step();
            bus.shift_x = 1'b0;
            bus.shift_y = 1'b0;
        end
    endtask

    task automatic do_frame_start();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic run_lines(int v_first, int v_last);
        for (int v = v_first; v <= v_last; v++) begin
            for (int h = 0; h < 100; h++) begin
                bus.counter_v = 10'(v);
                bus.counter_h = 10'(h);
                step();
            end
        end
        bus.counter_h = 10'd1023;
        bus.counter_v = 10'd1023;
    endtask

    logic [143:0] pat_a, pat_b;

    initial begin
        reset_n              = 1'b0;
        bus.spi_sprite_shift = 1'b0;
        bus.spi_mosi_sync    = 1'b0;
        bus.shift_x          = 1'b0;
        bus.shift_y          = 1'b0;
        bus.mirror_x         = 1'b0;
        bus.mirror_y         = 1'b0;
        bus.frame_start      = 1'b0;
        bus.counter_h        = 10'd1023;
        bus.counter_v        = 10'd1023;
        model_reset();

        // Reset values
        #12;
        check("rst sprite_data",  {15'd0, bus.sprite_data},  16'd0);
        check("rst sprite_pixel", {15'd0, bus.sprite_pixel}, 16'd0);
        check("rst sprite_x",     {8'd0, bus.sprite_x},      16'd0);
        check("rst sprite_y",     {8'd0, bus.sprite_y},      16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First frame after reset never draws, even with a full bitmap at (0,0)
        for (int i = 0; i < 144; i++) shift_bm(1'b1);
        check("sprite_data after ones", {15'd0, bus.sprite_data}, 16'd1);
        run_lines(0, 50);

        // Single lit pixel (0,0), X=10 Y=5
        shift_bm(1'b1);
        for (int i = 0; i < 143; i++) shift_bm(1'b0);
        check("sprite_data first bit", {15'd0, bus.sprite_data}, 16'd1);
        shift_pos(1'b0, 8'd10);
        shift_pos(1'b1, 8'd5);
        check("sprite_x before commit", {8'd0, bus.sprite_x}, 16'd0);
        do_frame_start();
        check("sprite_x commit", {8'd0, bus.sprite_x}, 16'd10);
        check("sprite_y commit", {8'd0, bus.sprite_y}, 16'd5);
        run_lines(0, 72);

        // Mirrored in both axes
        bus.mirror_x = 1'b1;
        bus.mirror_y = 1'b1;
        do_frame_start();
        run_lines(0, 72);
        bus.mirror_x = 1'b0;
        bus.mirror_y = 1'b0;

        // Shadow write mid-frame does not move the sprite until frame_start
        do_frame_start();
        run_lines(0, 10);
        shift_pos(1'b0, 8'd20);
        check("sprite_x mid-frame", {8'd0, bus.sprite_x}, 16'd10);
        run_lines(11, 72);
        bus.spi_mosi_sync = 1'b1;
        bus.shift_x       = 1'b1;
        bus.frame_start   = 1'b1;
        step();
        bus.shift_x     = 1'b0;
        bus.frame_start = 1'b0;
        check("sprite_x coincident commit", {8'd0, bus.sprite_x}, 16'd20);
        do_frame_start();
        check("sprite_x post-shift shadow", {8'd0, bus.sprite_x}, 16'd41);

        // Origin, full bitmap: x0==0 coincides with the line event
        shift_pos(1'b0, 8'd0);
        shift_pos(1'b1, 8'd0);
        for (int i = 0; i < 144; i++) shift_bm(1'b1);
        do_frame_start();
        check("sprite_x origin", {8'd0, bus.sprite_x}, 16'd0);
        run_lines(0, 72);

        // Off-screen Y never draws
        shift_pos(1'b1, 8'd255);
        do_frame_start();
        check("sprite_y offscreen", {8'd0, bus.sprite_y}, 16'd255);
        run_lines(0, 30);

        // Readback: while B is shifted in, sprite_data replays A in send order
        for (int i = 0; i < 144; i += 16) begin
            pat_a[i +: 16] = 16'($urandom);
            pat_b[i +: 16] = 16'($urandom);
        end
        for (int i = 0; i < 144; i++) shift_bm(pat_a[i]);
        for (int i = 0; i < 144; i++) begin
            check($sformatf("readback bit %0d", i), {15'd0, bus.sprite_data}, {15'd0, pat_a[i]});
            shift_bm(pat_b[i]);
        end

        // Reset mid-line while the sprite is being drawn
        shift_pos(1'b1, 8'd0);
        for (int i = 0; i < 144; i++) shift_bm(1'b1);
        do_frame_start();
        run_lines(0, 2);
        for (int h = 0; h <= 10; h++) begin
            bus.counter_v = 10'd3;
            bus.counter_h = 10'(h);
            step();
        end
        reset_n = 1'b0;
        #1;
        check("pixel at async reset", {15'd0, bus.sprite_pixel}, 16'd0);
        check("sprite_data at reset", {15'd0, bus.sprite_data},  16'd0);
        check("sprite_y at reset",    {8'd0, bus.sprite_y},      16'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("pixel held in reset", {15'd0, bus.sprite_pixel}, 16'd0);
        reset_n       = 1'b1;
        bus.counter_h = 10'd1023;
        bus.counter_v = 10'd1023;

        // No output until the next frame_start, then drawing resumes at the default position
        for (int i = 0; i < 144; i++) shift_bm(1'b1);
        run_lines(0, 20);
        do_frame_start();
        run_lines(0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
